// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding memory port between fetch (IFU) and load/store (LSU),
// favouring LSU but forcing an IFU grant after STARVE_LIMIT consecutive LSU grants while IFU waits.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        ifu_req_i,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_gnt_o,
  output logic        ifu_rvalid_o,
  output logic [31:0] ifu_rdata_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);
  typedef enum logic {IDLE, WAIT_RSP} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t     r_state, w_state_nxt;
  logic       r_owner_lsu, w_owner_lsu_nxt;
  logic [3:0] r_streak, w_streak_nxt;
  logic       w_window, w_sel_ifu, w_sel_lsu, w_grant;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_owner_lsu <= 1'b0;
      r_streak    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner_lsu <= w_owner_lsu_nxt;
      r_streak    <= w_streak_nxt;
    end
  end
  always_comb begin
    // a new request may issue in the same cycle the outstanding response returns
    w_window        = (r_state == IDLE) || (r_state == WAIT_RSP && mem_rvalid_i);
    w_sel_ifu       = w_window && ifu_req_i && (!lsu_req_i || r_streak == LIMIT);
    w_sel_lsu       = w_window && lsu_req_i && !w_sel_ifu;
    mem_req_o       = w_sel_ifu || w_sel_lsu;
    mem_we_o        = w_sel_lsu && lsu_we_i;
    mem_be_o        = w_sel_lsu ? lsu_be_i : (w_sel_ifu ? 4'hF : 4'h0);
    mem_addr_o      = w_sel_lsu ? lsu_addr_i : (w_sel_ifu ? ifu_addr_i : 32'h0);
    mem_wdata_o     = w_sel_lsu ? lsu_wdata_i : 32'h0;
    ifu_gnt_o       = w_sel_ifu && mem_gnt_i;
    lsu_gnt_o       = w_sel_lsu && mem_gnt_i;
    w_grant         = mem_req_o && mem_gnt_i;
    w_state_nxt     = w_grant ? WAIT_RSP : ((r_state == WAIT_RSP && mem_rvalid_i) ? IDLE : r_state);
    w_owner_lsu_nxt = w_grant ? w_sel_lsu : r_owner_lsu;
    w_streak_nxt    = (!ifu_req_i || ifu_gnt_o) ? 4'h0
                    : ((lsu_gnt_o && r_streak != LIMIT) ? r_streak + 4'h1 : r_streak);
    ifu_rvalid_o    = mem_rvalid_i && r_state == WAIT_RSP && !r_owner_lsu;
    lsu_rvalid_o    = mem_rvalid_i && r_state == WAIT_RSP && r_owner_lsu;
    ifu_rdata_o     = mem_rdata_i;
    lsu_rdata_o     = mem_rdata_i;
    busy_o          = (r_state == WAIT_RSP);
  end
endmodule
